decode_pipe: RTL and testbench

DECODE_PIPE -- requirements
Module: decode_pipe

---
 rtl/decode_pipe.sv | 164 ++++++++++++++++
 tb/tb_decode_pipe.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/decode_pipe.sv
// Instruction decode stage: decodes in_inst into a control/operand bundle behind a
// one- or two-entry elastic buffer. Define DECODE_PIPE_ILLEGAL_EN to flag undefined opcodes and halt on them.
module decode_pipe #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_inst,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [4:0]       out_opcode,
   output logic [4:0]       out_ctrl,
   output logic [3:0]       out_cc,
   output logic [4:0]       out_sel,
   output logic [14:0]      out_addr,
   output logic [WIDTH-1:0] out_a_data,
   output logic [WIDTH-1:0] out_b_data,
   output logic             out_illegal,
   output logic             halted
);

   // state  | meaning
   // RUN    | accepting instructions
   // HALTED | HALT (or illegal opcode) accepted; input blocked until flush
   typedef enum logic {RUN, HALTED} state_t;

   localparam logic [4:0] OP_NOP  = 5'd0;
   localparam logic [4:0] OP_MOV  = 5'd1;
   localparam logic [4:0] OP_MOVH = 5'd2;
   localparam logic [4:0] OP_BR   = 5'd3;
   localparam logic [4:0] OP_CALL = 5'd4;
   localparam logic [4:0] OP_RET  = 5'd5;
   localparam logic [4:0] OP_HALT = 5'd6;
   localparam logic [4:0] OP_LD   = 5'd8;
   localparam logic [4:0] OP_ST   = 5'd9;
   localparam logic [4:0] OP_ADD  = 5'd16;
   localparam logic [4:0] OP_CMP  = 5'd25;

   localparam logic P_REGS = 1'b1;
   localparam logic S_REGS = 1'b0;

   typedef struct packed {
      logic [4:0]       opcode;
      logic [4:0]       ctrl;
      logic [3:0]       cc;
      logic [4:0]       sel;
      logic [14:0]      addr;
      logic [WIDTH-1:0] a_data;
      logic [WIDTH-1:0] b_data;
      logic             illegal;
   } bundle_t;

   state_t  state;
   bundle_t out_r, skid_r, dec;
   logic    out_valid_r, skid_valid;
   logic    in_fire, halt_like;

   logic [4:0] op;
   logic       is_mov, is_movh, is_br, is_call, is_ret, is_halt, is_alu, is_cmp;
   logic       large_imm, small_imm, defined;
   logic [4:0] a_addr, b_addr, z_addr;
   logic       unused_inst;

   assign unused_inst = ^in_inst;

   always_comb begin
      op        = in_inst[WIDTH-1:WIDTH-5];
      is_mov    = (op == OP_MOV);
      is_movh   = (op == OP_MOVH);
      is_br     = (op == OP_BR);
      is_call   = (op == OP_CALL);
      is_ret    = (op == OP_RET);
      is_halt   = (op == OP_HALT);
      is_cmp    = (op == OP_CMP);
      is_alu    = (op >= OP_ADD) && (op <= OP_CMP);
      large_imm = is_mov | is_movh | is_br | is_call;
      small_imm = is_alu & in_inst[WIDTH-6];
      defined   = is_alu || (op <= OP_HALT) || (op == OP_LD) || (op == OP_ST);

      a_addr = is_br ? {2'b00, in_inst[18:16]} : is_ret ? 5'd31 : large_imm ? 5'd0 : in_inst[9:5];
      b_addr = large_imm ? 5'd0 : in_inst[4:0];
      z_addr = is_br ? 5'd0 : is_call ? 5'd31 : in_inst[20:16];

      dec        = '0;
      dec.opcode = op;
      dec.ctrl   = {is_br, is_br & in_inst[19], is_call, is_ret, is_halt};
      dec.cc     = is_cmp ? in_inst[13:10] : 4'd0;
      dec.sel    = {(is_br ? P_REGS : S_REGS), ~large_imm, S_REGS, ~large_imm & ~small_imm,
                    (is_cmp ? P_REGS : S_REGS)};
      dec.addr   = {a_addr, b_addr, z_addr};
      if (is_mov || is_movh)
         dec.a_data = {{(WIDTH-16){1'b0}}, in_inst[15:0]};
      else
         dec.a_data = {{(WIDTH-16){in_inst[15]}}, in_inst[15:0]};
      if (small_imm)
         dec.b_data = {{(WIDTH-6){in_inst[WIDTH-7]}}, in_inst[WIDTH-7], in_inst[4:0]};
      else
         dec.b_data = {{(WIDTH-5){1'b0}}, in_inst[4:0]};
`ifdef DECODE_PIPE_ILLEGAL_EN
      dec.illegal = ~defined;
      halt_like   = is_halt | ~defined;
`else
      dec.illegal = 1'b0;
      halt_like   = is_halt | (defined & 1'b0);
`endif
   end

   // Both buffer flags and the state are registers; rst_n/flush only mask them.
   always_comb begin
      if (DEPTH > 1)
         in_ready = rst_n & ~flush & (state == RUN) & ~skid_valid;
      else
         in_ready = rst_n & ~flush & (state == RUN) & (~out_valid_r | out_ready);
   end

   assign in_fire = in_valid & in_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= RUN;
         out_valid_r <= 1'b0;
         skid_valid  <= 1'b0;
         out_r       <= '0;
         skid_r      <= '0;
      end else if (flush) begin
         state       <= RUN;
         out_valid_r <= 1'b0;
         skid_valid  <= 1'b0;
      end else begin
         if (in_fire && halt_like)
            state <= HALTED;
         if (!out_valid_r || out_ready) begin
            if (DEPTH > 1 && skid_valid) begin
               out_r       <= skid_r;
               out_valid_r <= 1'b1;
               skid_valid  <= 1'b0;
            end else begin
               out_valid_r <= in_fire;
               if (in_fire)
                  out_r <= dec;
            end
         end else if (DEPTH > 1 && in_fire) begin
            skid_r     <= dec;
            skid_valid <= 1'b1;
         end
      end
   end

   assign out_valid   = out_valid_r;
   assign out_opcode  = out_r.opcode;
   assign out_ctrl    = out_r.ctrl;
   assign out_cc      = out_r.cc;
   assign out_sel     = out_r.sel;
   assign out_addr    = out_r.addr;
   assign out_a_data  = out_r.a_data;
   assign out_b_data  = out_r.b_data;
   assign out_illegal = out_r.illegal;
   assign halted      = (state == HALTED);

endmodule

// File: tb/tb_decode_pipe.sv
// Bench for decode_pipe (WIDTH=32, DEPTH=2): decode vector table, skid stall ordering,
// halt/flush, reset and undefined-opcode handling.
module tb_decode_pipe;
   logic        clk = 1'b0;
   logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready, out_illegal, halted;
   logic [31:0] in_inst, out_a_data, out_b_data;
   logic [4:0]  out_opcode, out_ctrl, out_sel;
   logic [3:0]  out_cc;
   logic [14:0] out_addr;
   int total = 0;
   int bad   = 0;

   decode_pipe #(.WIDTH(32), .DEPTH(2)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_inst(in_inst), .out_valid(out_valid), .out_ready(out_ready), .out_opcode(out_opcode),
      .out_ctrl(out_ctrl), .out_cc(out_cc), .out_sel(out_sel), .out_addr(out_addr),
      .out_a_data(out_a_data), .out_b_data(out_b_data), .out_illegal(out_illegal), .halted(halted)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] inst;
      logic [4:0]  ctrl;
      logic [3:0]  cc;
      logic [4:0]  sel;
      logic [14:0] addr;
      logic [31:0] a_data;
      logic [31:0] b_data;
   } vec_t;

   vec_t        vt[13];
   logic [31:0] tok[6];
   logic [31:0] cur;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   initial begin
      int sent, got;
      vt[0]  = '{32'h84000003, 5'b00000, 4'h0, 5'b01000, {5'd0, 5'd3, 5'd0}, 32'h3, 32'h3};
      vt[1]  = '{{5'd17, 1'b0, 5'd0, 5'd7, 6'd0, 5'd2, 5'd9}, 5'b00000, 4'h0, 5'b01010,
                 {5'd2, 5'd9, 5'd7}, 32'h49, 32'h9};
      vt[2]  = '{{5'd25, 1'b1, 1'b1, 4'd0, 5'd0, 2'd0, 4'b1010, 5'd3, 5'd30}, 5'b00000, 4'hA,
                 5'b01001, {5'd3, 5'd30, 5'd0}, 32'h287E, 32'hFFFFFFFE};
      vt[3]  = '{{5'd1, 6'd0, 5'd12, 16'h8001}, 5'b00000, 4'h0, 5'b00000, {5'd0, 5'd0, 5'd12},
                 32'h00008001, 32'h1};
      vt[4]  = '{{5'd2, 6'd0, 5'd3, 16'hFFFF}, 5'b00000, 4'h0, 5'b00000, {5'd0, 5'd0, 5'd3},
                 32'h0000FFFF, 32'h1F};
      vt[5]  = '{{5'd3, 6'd0, 5'b01101, 16'hFFF0}, 5'b11000, 4'h0, 5'b10000, {5'd5, 5'd0, 5'd0},
                 32'hFFFFFFF0, 32'h10};
      vt[6]  = '{{5'd3, 6'd0, 5'b00010, 16'h0004}, 5'b10000, 4'h0, 5'b10000, {5'd2, 5'd0, 5'd0},
                 32'h4, 32'h4};
      vt[7]  = '{{5'd4, 6'd0, 5'd9, 16'h1234}, 5'b00100, 4'h0, 5'b00000, {5'd0, 5'd0, 5'd31},
                 32'h1234, 32'h14};
      vt[8]  = '{{5'd5, 6'd0, 5'd0, 6'd0, 5'd4, 5'd6}, 5'b00010, 4'h0, 5'b01010,
                 {5'd31, 5'd6, 5'd0}, 32'h86, 32'h6};
      vt[9]  = '{{5'd16, 1'b1, 1'b1, 25'd0}, 5'b00000, 4'h0, 5'b01000, 15'd0, 32'h0, 32'hFFFFFFE0};
      vt[10] = '{{5'd8, 1'b1, 1'b1, 20'd0, 5'd5}, 5'b00000, 4'h0, 5'b01010, {5'd0, 5'd5, 5'd0},
                 32'h5, 32'h5};
      vt[11] = '{32'h0, 5'b00000, 4'h0, 5'b01010, 15'd0, 32'h0, 32'h0};
      vt[12] = '{{5'd21, 1'b1, 1'b0, 4'd0, 5'd4, 6'd0, 5'd1, 5'd17}, 5'b00000, 4'h0, 5'b01000,
                 {5'd1, 5'd17, 5'd4}, 32'h31, 32'h11};
      for (int k = 0; k < 6; k++) tok[k] = 32'h88000000 | (k + 1);

      // reset
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_inst = 32'h0;
      @(negedge clk); @(negedge clk); #1;
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_halted", halted, 0);
      chk("rst_a_data", out_a_data, 0);
      chk("rst_addr", out_addr, 0);
      chk("rst_illegal", out_illegal, 0);
      @(negedge clk); rst_n = 1'b1; #1;
      chk("post_rst_in_ready", in_ready, 1);

      // decode table, one instruction at a time
      for (int i = 0; i < 13; i++) begin
         @(negedge clk); in_valid = 1'b1; in_inst = vt[i].inst; #1;
         chk("vec_in_ready", in_ready, 1);
         @(negedge clk); in_valid = 1'b0; #1;
         cur = vt[i].inst;
         chk("vec_valid", out_valid, 1);
         chk("vec_opcode", out_opcode, cur[31:27]);
         chk("vec_ctrl", out_ctrl, vt[i].ctrl);
         chk("vec_cc", out_cc, vt[i].cc);
         chk("vec_sel", out_sel, vt[i].sel);
         chk("vec_addr", out_addr, vt[i].addr);
         chk("vec_a_data", out_a_data, vt[i].a_data);
         chk("vec_b_data", out_b_data, vt[i].b_data);
         chk("vec_illegal", out_illegal, 0);
      end
      @(negedge clk); #1;
      chk("idle_valid", out_valid, 0);

      // back-to-back stream with a 3-cycle consumer stall
      sent = 0; got = 0;
      for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
         @(negedge clk);
         out_ready = !(cyc >= 1 && cyc <= 3);
         in_valid  = (sent < 6);
         in_inst   = (sent < 6) ? tok[sent] : 32'h0;
         #1;
         if (cyc == 1) chk("skid_accept", in_ready, 1);
         if (cyc == 2 || cyc == 3) begin
            chk("stall_in_ready", in_ready, 0);
            chk("stall_hold", out_addr[9:5], 1);
         end
         if (in_valid && in_ready) sent++;
         if (out_valid && out_ready) begin
            chk("order", out_addr[9:5], 5'(got + 1));
            got++;
         end
      end
      chk("stall_count", got, 6);
      in_valid = 1'b0; out_ready = 1'b1;

      // HALT then flush
      @(negedge clk); in_valid = 1'b1; in_inst = 32'h30000000; #1;
      chk("halt_accept", in_ready, 1);
      @(negedge clk); in_inst = 32'h0; #1;
      chk("halt_bundle_valid", out_valid, 1);
      chk("halt_bundle_ctrl", out_ctrl, 5'b00001);
      chk("halt_halted", halted, 1);
      chk("halt_in_ready", in_ready, 0);
      @(negedge clk); #1;
      chk("halt_drained", out_valid, 0);
      chk("halt_still_blocked", in_ready, 0);
      @(negedge clk); flush = 1'b1; in_inst = 32'h30000000; #1;
      chk("flush_in_ready", in_ready, 0);
      @(negedge clk); flush = 1'b0; in_valid = 1'b0; #1;
      chk("flush_halted", halted, 0);
      chk("flush_out_valid", out_valid, 0);
      chk("flush_in_ready_after", in_ready, 1);

      // flush discards buffered entries
      @(negedge clk); out_ready = 1'b0; in_valid = 1'b1; in_inst = tok[0];
      @(negedge clk); in_inst = tok[1];
      @(negedge clk); in_valid = 1'b0; flush = 1'b1;
      @(negedge clk); flush = 1'b0; out_ready = 1'b1; #1;
      chk("flush_buf_valid", out_valid, 0);
      chk("flush_buf_ready", in_ready, 1);
      @(negedge clk); #1;
      chk("flush_buf_nothing", out_valid, 0);

      // reset mid-stream
      @(negedge clk); out_ready = 1'b0; in_valid = 1'b1; in_inst = tok[2];
      @(negedge clk); in_inst = tok[3];
      @(negedge clk); in_valid = 1'b0; rst_n = 1'b0; #1;
      chk("midrst_in_ready", in_ready, 0);
      @(negedge clk); rst_n = 1'b1; out_ready = 1'b1; #1;
      chk("midrst_valid", out_valid, 0);
      chk("midrst_a_data", out_a_data, 0);
      chk("midrst_in_ready_after", in_ready, 1);
      @(negedge clk); #1;
      chk("midrst_nothing", out_valid, 0);

      // undefined opcode 5'b11111
      @(negedge clk); in_valid = 1'b1; in_inst = 32'hF8000000; #1;
      chk("undef_accept", in_ready, 1);
      @(negedge clk); in_valid = 1'b0; #1;
      chk("undef_valid", out_valid, 1);
      chk("undef_sel", out_sel, 5'b01010);
`ifdef DECODE_PIPE_ILLEGAL_EN
      chk("undef_illegal", out_illegal, 1);
      chk("undef_halted", halted, 1);
      chk("undef_in_ready", in_ready, 0);
      @(negedge clk); flush = 1'b1;
      @(negedge clk); flush = 1'b0;
`else
      chk("undef_illegal", out_illegal, 0);
      chk("undef_halted", halted, 0);
      chk("undef_in_ready", in_ready, 1);
`endif
      @(negedge clk); in_valid = 1'b1; in_inst = vt[0].inst; #1;
      chk("undef_resume", in_ready, 1);
      @(negedge clk); in_valid = 1'b0; #1;
      chk("undef_next_b", out_b_data, 32'h3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
